crc_engine: RTL

- Parametrised successor to the fixed CRC-8 tx_crc/rx_crc pair: one serial/multi-bit LFSR CRC engine with run-time generate/check mode.
- Configurable polynomial, CRC width, data width, init value and bits processed per cycle.
- Sits in the SerDes link layer: TX side generates the CRC appended to a frame; RX side checks the received frame plus CRC and flags errors.

---
 rtl/crc_engine.sv | 135 +++++++++++++
 1 files changed

// File: rtl/crc_engine.sv
// crc_engine: parametrised LFSR CRC generator/checker for the SerDes link layer.
// A frame {payload, crc_field} is captured on start and fed MSB-first through a
// non-augmented, non-reflected LFSR, BITS_PER_CYCLE bits per clock. Generate
// mode stops after the payload; check mode also runs the CRC field through and
// flags a non-zero residue.
module crc_engine #(
   parameter int                    DATA_LENGTH    = 64,
   parameter int                    CRC_LENGTH     = 10,
   parameter logic [CRC_LENGTH-1:0] POLY           = 10'h233,
   parameter logic [CRC_LENGTH-1:0] INIT           = '0,
   parameter int                    BITS_PER_CYCLE = 1,
   parameter int                    CNT_WIDTH      = $clog2(DATA_LENGTH+CRC_LENGTH+1)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              crc_start,
   input  logic                              crc_mode,
   input  logic                              crc_abort,
   input  logic [DATA_LENGTH+CRC_LENGTH-1:0] crc_data_i,
   output logic                              crc_busy,
   output logic                              crc_vld,
   output logic [CRC_LENGTH-1:0]             crc_o,
   output logic                              crc_err,
   output logic [CNT_WIDTH-1:0]              crc_cnt
);

   localparam int FRAME_LENGTH = DATA_LENGTH + CRC_LENGTH;

   // The bit counter only ever lands exactly on the payload or frame length
   // when the per-cycle step divides both.
   if (BITS_PER_CYCLE < 1 ||
       (DATA_LENGTH % BITS_PER_CYCLE) != 0 ||
       (CRC_LENGTH % BITS_PER_CYCLE) != 0) begin : g_bpc_check
      $fatal(1, "crc_engine: BITS_PER_CYCLE must divide DATA_LENGTH and CRC_LENGTH");
   end

   typedef enum logic {IDLE, CALC} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [FRAME_LENGTH-1:0] shreg;
   logic [CRC_LENGTH-1:0]   lfsr;
   logic [CRC_LENGTH-1:0]   lfsr_nxt;
   logic [CNT_WIDTH-1:0]    cnt;
   logic [CNT_WIDTH-1:0]    cnt_nxt;
   logic [CNT_WIDTH-1:0]    total;
   logic                    mode;
   logic                    vld;
   logic                    err;
   logic                    done;

   // Advance the LFSR over a group of bits, oldest (MSB) bit first.
   function automatic logic [CRC_LENGTH-1:0] lfsr_advance(
      input logic [CRC_LENGTH-1:0]     seed,
      input logic [BITS_PER_CYCLE-1:0] bits
   );
      logic [CRC_LENGTH-1:0] acc;
      logic                  fb;
      acc = seed;
      for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
         fb  = bits[i] ^ acc[CRC_LENGTH-1];
         acc = {acc[CRC_LENGTH-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
      return acc;
   endfunction

   assign lfsr_nxt = lfsr_advance(lfsr, shreg[FRAME_LENGTH-1 -: BITS_PER_CYCLE]);
   assign cnt_nxt  = cnt + CNT_WIDTH'(BITS_PER_CYCLE);
   assign done     = (cnt_nxt == total);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: start only from IDLE; abort or reaching the bit total ends CALC.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (crc_start) state_nxt = CALC;
         CALC:    if (crc_abort || done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture the frame on start, then shift and divide while in CALC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         lfsr  <= '0;
         cnt   <= '0;
         total <= '0;
         mode  <= 1'b0;
         vld   <= 1'b0;
         err   <= 1'b0;
      end else begin
         vld <= 1'b0;
         case (state)
            IDLE: begin
               if (crc_start) begin
                  shreg <= crc_data_i;
                  mode  <= crc_mode;
                  lfsr  <= INIT;
                  cnt   <= '0;
                  err   <= 1'b0;
                  total <= crc_mode ? CNT_WIDTH'(FRAME_LENGTH) : CNT_WIDTH'(DATA_LENGTH);
               end
            end
            CALC: begin
               // The abort edge still consumes its bits so crc_o/crc_cnt show
               // how far the division got; only the completion is suppressed.
               shreg <= shreg << BITS_PER_CYCLE;
               lfsr  <= lfsr_nxt;
               cnt   <= cnt_nxt;
               if (done && !crc_abort) begin
                  vld <= 1'b1;
                  err <= mode && (lfsr_nxt != '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign crc_busy = (state == CALC);
   assign crc_vld  = vld;
   assign crc_o    = lfsr;
   assign crc_err  = err;
   assign crc_cnt  = cnt;

endmodule
